// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        counter_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]     opnd_reg;
   logic                 is_div_reg;
   logic [WIDTH-1:0]     hi_reg, lo_reg;
   logic                 dbz_reg;

   logic                 last_step;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift, div_diff;
   logic [2*WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH-1:0]     hi_commit, lo_commit;

   assign last_step = (counter_reg == CW'(WIDTH - 1));

   // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
   // Divide:   acc = {remainder, dividend/quotient bits}, shifted left each step.
   always_comb begin
      mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
      div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_reg};
      if (is_div_reg)
         step_acc = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_reg[WIDTH-2:0], ~div_diff[WIDTH]};
      else
         step_acc = {mul_sum, acc_reg[WIDTH-1:1]};
   end

`ifdef MULDIV_SIGNED_EN
   logic               a_neg, b_neg;
   logic               neg_q_reg, neg_r_reg;
   logic [WIDTH-1:0]   a_orig_reg;
   logic [2*WIDTH-1:0] prod_fix;

   always_comb begin
      a_neg     = (op == 3'b010 || op == 3'b011) && a[WIDTH-1];
      b_neg     = (op == 3'b010 || op == 3'b011) && b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      prod_fix  = neg_q_reg ? -step_acc : step_acc;
      hi_commit = prod_fix[2*WIDTH-1:WIDTH];
      lo_commit = prod_fix[WIDTH-1:0];
      if (is_div_reg) begin
         // Divide by zero keeps the raw dividend rather than a sign-fixed magnitude.
         if (dbz_reg) begin
            hi_commit = a_orig_reg;
            lo_commit = '1;
         end else begin
            hi_commit = neg_r_reg ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
            lo_commit = neg_q_reg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         a_orig_reg <= '0;
      end else if (state_reg != S_RUN && start && op[2] == 1'b0) begin
         neg_q_reg  <= a_neg ^ b_neg;
         neg_r_reg  <= a_neg;
         a_orig_reg <= a;
      end
   end
`else
   always_comb begin
      a_mag     = a;
      b_mag     = b;
      hi_commit = step_acc[2*WIDTH-1:WIDTH];
      lo_commit = step_acc[WIDTH-1:0];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RUN:   if (last_step) state_next = S_DONE;
         default: state_next = (start && op[2] == 1'b0) ? S_RUN : S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter_reg <= '0;
         acc_reg     <= '0;
         opnd_reg    <= '0;
         is_div_reg  <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         dbz_reg     <= 1'b0;
      end else if (state_reg == S_RUN) begin
         acc_reg     <= step_acc;
         counter_reg <= counter_reg + 1'b1;
         if (last_step) begin
            hi_reg <= hi_commit;
            lo_reg <= lo_commit;
         end
      end else if (start) begin
         case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
               counter_reg <= '0;
               is_div_reg  <= op[0];
               acc_reg     <= {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
               opnd_reg    <= op[0] ? b_mag : a_mag;
               dbz_reg     <= op[0] && (b == '0);
            end
            3'b100:  hi_reg <= a;
            3'b101:  lo_reg <= a;
            default: ;
         endcase
      end
   end

   assign hi          = hi_reg;
   assign lo          = lo_reg;
   assign div_by_zero = dbz_reg;
   assign rd_data     = hilo_sel ? hi_reg : lo_reg;

endmodule
